// File: rtl/pulse_sequencer.sv
// pulse_sequencer: instruction-driven pulse scheduler.
// Pops 32-bit instruction words, decodes NOP/WAIT/EMIT/SYNC/HALT, pulls one
// pulse descriptor per EMIT, and drives a registered timed pulse.
// Optional build macro SEQ_TIMESTAMP_EN adds a free-running TS_W-bit counter
// whose value is captured into pulse_ts on each pulse_out rising edge;
// without it pulse_ts is tied to zero.
// SYNC_STAGES must be at least 2.
module pulse_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int TS_W        = 48
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            sync_in,
  input  logic            instr_empty,
  input  logic [31:0]     instr_dout,
  output logic            instr_rd_en,
  input  logic            pulse_empty,
  input  logic [31:0]     pulse_dout,
  output logic            pulse_rd_en,
  output logic            pulse_out,
  output logic            busy,
  output logic            halted,
  output logic            err,
  output logic [TS_W-1:0] pulse_ts
);

  localparam int CNT_W = 28;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_WAIT = 4'd1;
  localparam logic [3:0] OP_EMIT = 4'd2;
  localparam logic [3:0] OP_SYNC = 4'd3;
  localparam logic [3:0] OP_HALT = 4'd4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WAIT,
    S_PFETCH,
    S_PLOAD,
    S_DELAY,
    S_PULSE,
    S_SYNC,
    S_HALT
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [15:0]        pw, pw_nxt;
  logic               err_set;
  logic               pulse_q;
  logic               pulse_rise;

  // instruction / descriptor fields, only meaningful in DECODE / PLOAD
  logic [3:0]         op;
  logic [CNT_W-1:0]   arg;
  logic [15:0]        p_delay;
  logic [15:0]        p_width;

  assign op      = instr_dout[31:28];
  assign arg     = instr_dout[27:0];
  assign p_delay = pulse_dout[31:16];
  assign p_width = pulse_dout[15:0];

  // sync_in synchronizer; the extra top bit holds the previous synchronized
  // value so a rising edge is a single-cycle strobe
  logic [SYNC_STAGES:0] sync_pipe;
  logic                 sync_rise;

  // shift sync_in through the synchronizer chain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_pipe <= '0;
    else      sync_pipe <= {sync_pipe[SYNC_STAGES-1:0], sync_in};
  end

  assign sync_rise = sync_pipe[SYNC_STAGES-1] & ~sync_pipe[SYNC_STAGES];

  // state, shared down-counter, latched width and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      pw    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pw    <= pw_nxt;
      if (err_set) err <= 1'b1;
    end
  end

  // next-state decode; cnt serves WAIT, DELAY and PULSE in turn and always
  // exits on 1 so each state lasts exactly its loaded count
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pw_nxt    = pw;
    err_set   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run && !instr_empty) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        unique case (op)
          OP_NOP:  state_nxt = S_IDLE;
          OP_WAIT: begin
            cnt_nxt   = arg;
            state_nxt = (arg == '0) ? S_IDLE : S_WAIT;
          end
          OP_EMIT: state_nxt = S_PFETCH;
          OP_SYNC: state_nxt = S_SYNC;
          OP_HALT: state_nxt = S_HALT;
          default: begin
            err_set   = 1'b1;
            state_nxt = S_IDLE;
          end
        endcase
      end
      S_WAIT: begin
        if (cnt == CNT_W'(1)) state_nxt = S_IDLE;
        cnt_nxt = cnt - CNT_W'(1);
      end
      S_PFETCH: begin
        if (!pulse_empty) state_nxt = S_PLOAD;
      end
      S_PLOAD: begin
        pw_nxt = p_width;
        if (p_delay != '0) begin
          cnt_nxt   = CNT_W'(p_delay);
          state_nxt = S_DELAY;
        end else if (p_width != '0) begin
          cnt_nxt   = CNT_W'(p_width);
          state_nxt = S_PULSE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_DELAY: begin
        if (cnt == CNT_W'(1)) begin
          if (pw != '0) begin
            cnt_nxt   = CNT_W'(pw);
            state_nxt = S_PULSE;
          end else begin
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_PULSE: begin
        if (cnt == CNT_W'(1)) state_nxt = S_IDLE;
        cnt_nxt = cnt - CNT_W'(1);
      end
      S_SYNC: begin
        if (sync_rise) state_nxt = S_IDLE;
      end
      S_HALT: begin
        if (!run) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // pulse_out is a flop that mirrors the upcoming PULSE state, so it is
  // glitch-free and still drops with the asynchronous reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pulse_q <= 1'b0;
    else      pulse_q <= (state_nxt == S_PULSE);
  end

  assign pulse_rise  = (state_nxt == S_PULSE) && !pulse_q;

  assign pulse_out   = pulse_q;
  assign instr_rd_en = (state == S_FETCH);
  assign pulse_rd_en = (state == S_PFETCH) && !pulse_empty;
  assign busy        = (state != S_IDLE);
  assign halted      = (state == S_HALT);

`ifdef SEQ_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_q;

  // free-running timestamp, wraps naturally after all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_cnt <= '0;
    else      ts_cnt <= ts_cnt + TS_W'(1);
  end

  // capture the counter value seen during the first high cycle of pulse_out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            ts_q <= '0;
    else if (pulse_rise) ts_q <= ts_cnt + TS_W'(1);
  end

  assign pulse_ts = ts_q;
`else
  logic unused_rise;
  assign unused_rise = pulse_rise;
  assign pulse_ts    = '0;
`endif

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: small FIFO models feed instructions and
// descriptors; a vector table covers single-instruction timing, hand-written
// sequences cover PFETCH stall, async reset mid-pulse and SYNC/HALT.
module tb_pulse_sequencer;

  localparam int SS   = 2;
  localparam int TS_W = 48;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            run = 1'b0;
  logic            sync_in = 1'b0;
  logic            instr_empty;
  logic [31:0]     instr_dout = '0;
  logic            instr_rd_en;
  logic            pulse_empty;
  logic [31:0]     pulse_dout = '0;
  logic            pulse_rd_en;
  logic            pulse_out;
  logic            busy;
  logic            halted;
  logic            err;
  logic [TS_W-1:0] pulse_ts;

  pulse_sequencer #(.SYNC_STAGES(SS), .TS_W(TS_W)) dut (
    .clk(clk), .rst(rst), .run(run), .sync_in(sync_in),
    .instr_empty(instr_empty), .instr_dout(instr_dout), .instr_rd_en(instr_rd_en),
    .pulse_empty(pulse_empty), .pulse_dout(pulse_dout), .pulse_rd_en(pulse_rd_en),
    .pulse_out(pulse_out), .busy(busy), .halted(halted), .err(err),
    .pulse_ts(pulse_ts)
  );

  always #5 clk = ~clk;

  // FIFO models: writer is the stimulus process, reader is the pop process
  logic [31:0] imem [64];
  logic [31:0] pmem [64];
  int iwr = 0, ird = 0, pwr = 0, prd = 0;
  int bad_rd = 0;

  always_comb instr_empty = (ird == iwr);
  always_comb pulse_empty = (prd == pwr);

  always @(posedge clk) begin
    if (instr_rd_en) begin
      if (instr_empty) bad_rd <= bad_rd + 1;
      else begin
        instr_dout <= imem[ird];
        ird <= ird + 1;
      end
    end
    if (pulse_rd_en) begin
      if (pulse_empty) bad_rd <= bad_rd + 1;
      else begin
        pulse_dout <= pmem[prd];
        prd <= prd + 1;
      end
    end
  end

`ifdef SEQ_TIMESTAMP_EN
  logic [TS_W-1:0] cyc;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= '0;
    else      cyc <= cyc + TS_W'(1);
  end
`endif

  int checks = 0;
  int errors = 0;
  logic [TS_W-1:0] exp_ts = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_i(input logic [31:0] w);
    imem[iwr] = w;
    iwr++;
  endtask

  task automatic push_p(input logic [31:0] w);
    pmem[pwr] = w;
    pwr++;
  endtask

  // wait for FETCH, then measure one instruction until the DUT goes idle
  task automatic run_vec(input string name, input int eb, input int er,
                         input int ew, input logic ee);
    int t, busy_n, pw_n, rise, rdn;
    t = 0;
    while (!instr_rd_en && t < 50) begin tick(); t++; end
    chk({name, "_fetch"}, 64'(instr_rd_en), 64'(1));
    busy_n = 0; pw_n = 0; rise = -1; rdn = 0; t = 0;
    while (busy && t < 500) begin
      if (instr_rd_en) rdn++;
      if (pulse_out) begin
        if (rise < 0) begin
          rise = t - 1;
`ifdef SEQ_TIMESTAMP_EN
          exp_ts = cyc;
`endif
        end
        pw_n++;
      end
      busy_n++;
      tick();
      t++;
    end
    chk({name, "_busy_len"}, 64'(busy_n), 64'(eb));
    chk({name, "_rise"},     64'(rise),   64'(er));
    chk({name, "_width"},    64'(pw_n),   64'(ew));
    chk({name, "_nfetch"},   64'(rdn),    64'(1));
    chk({name, "_err"},      64'(err),    64'(ee));
    chk({name, "_ts"},       64'(pulse_ts), 64'(exp_ts));
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        has_desc;
    logic [31:0] desc;
    int          exp_busy;
    int          exp_rise;
    int          exp_w;
    logic        exp_err;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int t, bad;

    // busy length = FETCH + DECODE + body; rise is counted from DECODE
    tbl[0]  = '{"nop",       32'h0000_0000, 1'b0, 32'h0,         2, -1, 0, 1'b0};
    tbl[1]  = '{"wait5",     32'h1000_0005, 1'b0, 32'h0,         7, -1, 0, 1'b0};
    tbl[2]  = '{"wait0",     32'h1000_0000, 1'b0, 32'h0,         2, -1, 0, 1'b0};
    tbl[3]  = '{"wait1",     32'h1000_0001, 1'b0, 32'h0,         3, -1, 0, 1'b0};
    tbl[4]  = '{"emit_3_4",  32'h2000_0000, 1'b1, 32'h0003_0004, 11, 6, 4, 1'b0};
    tbl[5]  = '{"emit_0_1",  32'h2000_0000, 1'b1, 32'h0000_0001, 5,  3, 1, 1'b0};
    tbl[6]  = '{"emit_0_0",  32'h2000_0000, 1'b1, 32'h0000_0000, 4, -1, 0, 1'b0};
    tbl[7]  = '{"emit_2_0",  32'h2000_0000, 1'b1, 32'h0002_0000, 6, -1, 0, 1'b0};
    tbl[8]  = '{"illegal5",  32'h5ABC_DEF0, 1'b0, 32'h0,         2, -1, 0, 1'b1};
    tbl[9]  = '{"nop_stky",  32'h0000_0000, 1'b0, 32'h0,         2, -1, 0, 1'b1};
    tbl[10] = '{"emit_1_2",  32'h2FFF_FFFF, 1'b1, 32'h0001_0002, 7,  4, 2, 1'b1};

    // reset values
    repeat (2) tick();
    chk("rst_instr_rd_en", 64'(instr_rd_en), 64'(0));
    chk("rst_pulse_rd_en", 64'(pulse_rd_en), 64'(0));
    chk("rst_pulse_out",   64'(pulse_out),   64'(0));
    chk("rst_busy",        64'(busy),        64'(0));
    chk("rst_halted",      64'(halted),      64'(0));
    chk("rst_err",         64'(err),         64'(0));
    chk("rst_pulse_ts",    64'(pulse_ts),    64'(0));
    @(negedge clk) rst = 1'b1;
    tick();

    // run with both FIFOs empty: nothing must move
    run = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy || instr_rd_en || pulse_rd_en) bad++;
      tick();
    end
    chk("idle_quiet", 64'(bad), 64'(0));

    // single-instruction vectors
    for (int i = 0; i < 11; i++) begin
      push_i(tbl[i].instr);
      if (tbl[i].has_desc) push_p(tbl[i].desc);
      run_vec(tbl[i].name, tbl[i].exp_busy, tbl[i].exp_rise, tbl[i].exp_w, tbl[i].exp_err);
    end

    // EMIT with pulse FIFO empty: stall in PFETCH, then a 1-cycle pulse
    push_i(32'h2000_0000);
    t = 0;
    while (!instr_rd_en && t < 50) begin tick(); t++; end
    chk("stall_fetch", 64'(instr_rd_en), 64'(1));
    repeat (2) tick();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy || pulse_rd_en || pulse_out) bad++;
      tick();
    end
    chk("stall_hold", 64'(bad), 64'(0));
    push_p(32'h0000_0001);
    #1;
    chk("stall_rd_en", 64'(pulse_rd_en), 64'(1));
    tick();
    chk("stall_pload_out", 64'(pulse_out), 64'(0));
    tick();
    chk("stall_pulse_hi", 64'(pulse_out), 64'(1));
    tick();
    chk("stall_pulse_lo", 64'(pulse_out), 64'(0));
    chk("stall_idle", 64'(busy), 64'(0));

    // asynchronous reset in the middle of a 100-cycle pulse
    push_i(32'h2000_0000);
    push_p(32'h0000_0064);
    t = 0;
    while (!pulse_out && t < 50) begin tick(); t++; end
    chk("rstp_rise", 64'(pulse_out), 64'(1));
    repeat (10) tick();
    chk("rstp_still_hi", 64'(pulse_out), 64'(1));
    rst = 1'b0;
    #1;
    chk("rstp_pulse_out",   64'(pulse_out),   64'(0));
    chk("rstp_busy",        64'(busy),        64'(0));
    chk("rstp_err",         64'(err),         64'(0));
    chk("rstp_halted",      64'(halted),      64'(0));
    chk("rstp_instr_rd_en", 64'(instr_rd_en), 64'(0));
    chk("rstp_pulse_rd_en", 64'(pulse_rd_en), 64'(0));
    chk("rstp_pulse_ts",    64'(pulse_ts),    64'(0));
    @(negedge clk) rst = 1'b1;
    exp_ts = '0;
    tick();
    push_i(32'h1000_0002);
    run_vec("post_rst_wait2", 4, -1, 0, 1'b0);

    // illegal 0xF, SYNC released by an edge, then HALT
    push_i(32'hF000_0000);
    push_i(32'h3000_0000);
    push_i(32'h4000_0000);
    t = 0;
    while (!instr_rd_en && t < 50) begin tick(); t++; end
    chk("sh_fetch_ill", 64'(instr_rd_en), 64'(1));
    tick();                       // DECODE of 0xF
    tick();                       // back to IDLE
    chk("sh_ill_idle", 64'(busy), 64'(0));
    chk("sh_err_set",  64'(err),  64'(1));
    tick();
    chk("sh_fetch_sync", 64'(instr_rd_en), 64'(1));
    tick();                       // DECODE of SYNC
    tick();                       // SYNC
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!busy) bad++;
      tick();
    end
    chk("sh_sync_hold", 64'(bad), 64'(0));
    sync_in = 1'b1;
    bad = 0;
    for (int i = 0; i < SS; i++) begin
      tick();
      if (!busy) bad++;
    end
    chk("sh_sync_not_early", 64'(bad), 64'(0));
    tick();
    chk("sh_sync_exit", 64'(busy), 64'(0));
    sync_in = 1'b0;
    tick();
    chk("sh_fetch_halt", 64'(instr_rd_en), 64'(1));
    tick();
    tick();
    chk("sh_halted", 64'(halted), 64'(1));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!halted || !busy) bad++;
    end
    chk("sh_halt_hold", 64'(bad), 64'(0));
    run = 1'b0;
    tick();
    chk("sh_halt_release", 64'(halted), 64'(0));
    chk("sh_idle_after",   64'(busy),   64'(0));
    chk("sh_err_sticky",   64'(err),    64'(1));

    // global FIFO discipline
    chk("rd_while_empty", 64'(bad_rd), 64'(0));
    chk("instr_drained",  64'(ird),    64'(iwr));
    chk("pulse_drained",  64'(prd),    64'(pwr));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_sequencer.md
# pulse_sequencer

Instruction-driven pulse scheduler that sits downstream of the GPIO-loaded instruction and pulse FIFOs. It pops 32-bit instruction words, decodes them, and, for EMIT instructions, pops one pulse descriptor to drive a timed pulse on `pulse_out`. It also stalls on WAIT counts and external sync edges. It is the sole reader of both FIFOs and the only source of the timing pulse to the optical front end.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `sync_in` (min 2).
- `TS_W`, 48: timestamp counter width (used only with `SEQ_TIMESTAMP_EN`).

- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `run`  in  1  fetch enable; level-sensitive.
- `sync_in`  in  1  asynchronous external sync; only rising edges are used.
- `instr_empty`  in  1  instruction FIFO empty.
- `instr_dout`  in  32  instruction FIFO data; valid the cycle after `instr_rd_en`.
- `instr_rd_en`  out  1  instruction FIFO pop, one-cycle pulse.
- `pulse_empty`  in  1  pulse FIFO empty.
- `pulse_dout`  in  32  pulse descriptor; `[31:16]` delay, `[15:0]` width; valid the cycle after `pulse_rd_en`.
- `pulse_rd_en`  out  1  pulse FIFO pop, one-cycle pulse.
- `pulse_out`  out  1  registered timing pulse.
- `busy`  out  1  high whenever state ≠ IDLE.
- `halted`  out  1  high in HALT.
- `err`  out  1  sticky illegal-opcode flag.
- `pulse_ts`  out  TS_W  timestamp of the last `pulse_out` rising edge.

## Operation
- Instruction word: `[31:28]` opcode, `[27:0]` arg. Opcodes:
  - 0 NOP.
  - 1 WAIT: arg cycles.
  - 2 EMIT.
  - 3 SYNC: wait for a `sync_in` rising edge.
  - 4 HALT.
  - 5–15 illegal: set `err` and are treated as NOP.
- States: IDLE, FETCH, DECODE, WAIT, PFETCH, PLOAD, DELAY, PULSE, SYNC, HALT.
- IDLE → FETCH when `run && !instr_empty`; otherwise stay.
- FETCH: `instr_rd_en`=1 for exactly this cycle → DECODE.
- DECODE: latch `instr_dout`, then dispatch:
  - NOP or illegal → IDLE.
  - WAIT → WAIT with counter=arg, or IDLE directly if arg=0.
  - EMIT → PFETCH.
  - SYNC → SYNC.
  - HALT → HALT.
- WAIT: decrement each cycle; → IDLE on the cycle the counter reaches 1, so the state lasts exactly arg cycles.
- PFETCH: stall while `pulse_empty` (`busy` stays high); when not empty, `pulse_rd_en`=1 for one cycle → PLOAD.
- PLOAD: latch delay and width.
  - → DELAY if delay>0.
  - else → PULSE if width>0.
  - else → IDLE, with no pulse and no timestamp update.
- DELAY: exactly delay cycles, then → PULSE, or → IDLE if width=0.
- PULSE: `pulse_out`=1 for exactly width cycles, then → IDLE.
- SYNC: → IDLE on the cycle after a synchronized rising edge is detected. Edges that occur outside SYNC state are ignored; there is no queuing.
- HALT: hold until `run`=0, then → IDLE.
- `run` deassertion does not abort an instruction in progress. It only blocks new fetches from IDLE.
- FIFO reads are never issued while the FIFO's empty flag is high.
- `err` is cleared only by reset.

## Timing
- Reset values:
  - outputs: `instr_rd_en`, `pulse_rd_en`, `pulse_out`, `busy`, `halted`, `err` = 0; `pulse_ts` = 0.
  - state IDLE; all counters 0.
- Reset mid-operation aborts immediately: `pulse_out` drops asynchronously and an in-flight FIFO word is discarded.
- Fetch latency: condition seen in IDLE at cycle N → `instr_rd_en` at N+1 → DECODE at N+2.
- EMIT, delay D, width W, pulse FIFO non-empty, DECODE at cycle T:
  - `pulse_rd_en` at T+1.
  - PLOAD at T+2.
  - `pulse_out` high on cycles T+3+D through T+2+D+W.
- Minimum spacing between back-to-back instructions: 3 cycles (IDLE, FETCH, DECODE).
- `sync_in` edge to SYNC exit: SYNC_STAGES+1 cycles.

## Configuration
- `SEQ_TIMESTAMP_EN` defined:
  - free-running TS_W-bit counter, cleared by reset, wraps to 0 after all-ones.
  - `pulse_ts` loads the counter value on the cycle `pulse_out` rises.
- Not defined: no counter is present and `pulse_ts` is tied to 0.

## Test plan
- Reset, then `run`=1 with both FIFOs empty → `busy`=0; no `instr_rd_en` or `pulse_rd_en` asserted for 100 cycles.
- Push WAIT arg=5 → `busy` high 2+5 cycles after FETCH; IDLE thereafter; `instr_rd_en` asserted exactly once.
- Push EMIT plus descriptor 0x0003_0004 → `pulse_out` high exactly 4 cycles, rising 6 cycles after DECODE. With `SEQ_TIMESTAMP_EN`, `pulse_ts` equals the counter value at that rise.
- EMIT with pulse FIFO empty for 20 cycles, then push 0x0000_0001 → stays in PFETCH for 20 cycles with `pulse_rd_en` low; then a 1-cycle pulse.
- Opcode 0xF, then SYNC with a `sync_in` edge 10 cycles later, then HALT:
  - `err`=1 and stays 1.
  - SYNC exits SYNC_STAGES+1 cycles after the edge.
  - `halted`=1 until `run`=0.
- Assert `rst` mid-PULSE (width 100) → `pulse_out` drops asynchronously; all outputs are at reset values; the next fetch starts cleanly.
